// File: rtl/vga_timing_gen_pkg.sv
// rtl/vga_timing_gen_pkg.sv - 640x480@60 default timing, counter width and sync polarity encoding
package vga_timing_gen_pkg;

  localparam int CNT_W   = 11;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_COLOR_W  = 4;
  localparam int DEF_PIX_LAT  = 1;

  localparam int SYNC_ACTIVE_LOW  = 0;
  localparam int SYNC_ACTIVE_HIGH = 1;
  localparam int DEF_SYNC_POL     = SYNC_ACTIVE_LOW;

  typedef struct packed {
    logic h_act;
    logic v_act;
    logic valid;
  } raster_flags_t;

  function automatic logic in_range(input logic [CNT_W-1:0] v,
                                    input logic [CNT_W-1:0] lo,
                                    input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_pix_ce_div.sv
// rtl/vga_timing_gen_pix_ce_div.sv - pixel clock-enable divider, one clk wide every CLK_DIV clks
module vga_pix_ce_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pix_ce
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;

  // With CLK_DIV=1 DIV_LAST is 0, so div never leaves 0 and pix_ce stays high.
  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  assign pix_ce = (div == '0);

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster generator with look-ahead pixel requests
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int SYNC_POL = DEF_SYNC_POL,
  parameter int COLOR_W  = DEF_COLOR_W,
  parameter int PIX_LAT  = DEF_PIX_LAT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COLOR_W-1:0] rin,
  input  logic [COLOR_W-1:0] gin,
  input  logic [COLOR_W-1:0] bin,
  output logic               pix_ce,
  output logic [CNT_W-1:0]   req_x,
  output logic [CNT_W-1:0]   req_y,
  output logic               req_valid,
  output logic               line_start,
  output logic               frame_start,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [COLOR_W-1:0] r,
  output logic [COLOR_W-1:0] g,
  output logic [COLOR_W-1:0] b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (CLK_DIV < 1) begin : g_bad_clk_div
      $error("vga_timing_gen: CLK_DIV must be at least 1");
    end
    if (PIX_LAT < 0 || PIX_LAT > 7) begin : g_bad_pix_lat
      $error("vga_timing_gen: PIX_LAT must be in 0..7");
    end
    if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX) begin : g_bad_total
      $error("vga_timing_gen: raster totals must not exceed 2047");
    end
  endgenerate

  localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic             IDLE_LVL = (SYNC_POL == SYNC_ACTIVE_HIGH) ? 1'b0 : 1'b1;

  raster_flags_t cur;
  raster_flags_t dly;

  vga_pix_ce_div #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_ce_div (
    .clk    (clk),
    .rst    (rst),
    .pix_ce (pix_ce)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      req_x <= '0;
      req_y <= '0;
    end else if (pix_ce) begin
      if (req_x == X_LAST) begin
        req_x <= '0;
        req_y <= (req_y == Y_LAST) ? '0 : req_y + 1'b1;
      end else begin
        req_x <= req_x + 1'b1;
      end
    end
  end

  assign req_valid   = (req_x < CNT_W'(H_ACTIVE)) && (req_y < CNT_W'(V_ACTIVE));
  assign line_start  = pix_ce && (req_x == '0);
  assign frame_start = line_start && (req_y == '0);

  always_comb begin
    cur       = '0;
    cur.h_act = in_range(req_x, HS_FIRST, HS_LAST);
    cur.v_act = in_range(req_y, VS_FIRST, VS_LAST);
    cur.valid = req_valid;
  end

  // Delay the request-side flags so they meet the pixel source's colour at the output register.
  generate
    if (PIX_LAT == 0) begin : g_no_delay
      assign dly = cur;
    end else begin : g_delay
      raster_flags_t stage [PIX_LAT];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < PIX_LAT; i++) stage[i] <= '0;
        end else if (pix_ce) begin
          stage[0] <= cur;
          for (int i = 1; i < PIX_LAT; i++) stage[i] <= stage[i-1];
        end
      end
      assign dly = stage[PIX_LAT-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      de    <= 1'b0;
      hsync <= IDLE_LVL;
      vsync <= IDLE_LVL;
      r     <= '0;
      g     <= '0;
      b     <= '0;
    end else if (pix_ce) begin
      de    <= dly.valid;
      hsync <= dly.h_act ^ IDLE_LVL;
      vsync <= dly.v_act ^ IDLE_LVL;
      r     <= dly.valid ? rin : '0;
      g     <= dly.valid ? gin : '0;
      b     <= dly.valid ? bin : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed table and sequence checks for vga_timing_gen
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // default timing instance (640x480, CLK_DIV 4, PIX_LAT 1, active-low syncs)
  logic d_rst = 1'b1;
  logic [3:0] d_rin = 4'h0;
  logic [3:0] d_gin = 4'hF;
  logic [3:0] d_bin = 4'h9;
  logic d_ce, d_valid, d_ls, d_fs, d_hs, d_vs, d_de;
  logic [10:0] d_x, d_y;
  logic [3:0] d_r, d_g, d_b;

  vga_timing_gen u_def (
    .clk(clk), .rst(d_rst), .rin(d_rin), .gin(d_gin), .bin(d_bin),
    .pix_ce(d_ce), .req_x(d_x), .req_y(d_y), .req_valid(d_valid),
    .line_start(d_ls), .frame_start(d_fs), .hsync(d_hs), .vsync(d_vs),
    .de(d_de), .r(d_r), .g(d_g), .b(d_b)
  );

  always @(posedge clk) if (d_ce) d_rin <= d_x[3:0];

  // small raster, CLK_DIV 2, PIX_LAT 1, active-low syncs: 30 x 13 totals
  logic m_rst = 1'b1;
  logic [3:0] m_rin = 4'h0;
  logic [3:0] m_gin = 4'h1;
  logic [3:0] m_bin = 4'h2;
  logic m_ce, m_valid, m_ls, m_fs, m_hs, m_vs, m_de;
  logic [10:0] m_x, m_y;
  logic [3:0] m_r, m_g, m_b;

  vga_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(0), .COLOR_W(4), .PIX_LAT(1)
  ) u_mid (
    .clk(clk), .rst(m_rst), .rin(m_rin), .gin(m_gin), .bin(m_bin),
    .pix_ce(m_ce), .req_x(m_x), .req_y(m_y), .req_valid(m_valid),
    .line_start(m_ls), .frame_start(m_fs), .hsync(m_hs), .vsync(m_vs),
    .de(m_de), .r(m_r), .g(m_g), .b(m_b)
  );

  always @(posedge clk) if (m_ce) m_rin <= m_x[3:0];

  // fast instance: CLK_DIV 1, PIX_LAT 0, active-high syncs, 14 x 7 totals
  logic f_rst = 1'b1;
  logic [3:0] f_rin;
  logic [3:0] f_gin = 4'h0;
  logic [3:0] f_bin = 4'h0;
  logic f_ce, f_valid, f_ls, f_fs, f_hs, f_vs, f_de;
  logic [10:0] f_x, f_y;
  logic [3:0] f_r, f_g, f_b;

  assign f_rin = f_x[3:0];

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1), .COLOR_W(4), .PIX_LAT(0)
  ) u_fast (
    .clk(clk), .rst(f_rst), .rin(f_rin), .gin(f_gin), .bin(f_bin),
    .pix_ce(f_ce), .req_x(f_x), .req_y(f_y), .req_valid(f_valid),
    .line_start(f_ls), .frame_start(f_fs), .hsync(f_hs), .vsync(f_vs),
    .de(f_de), .r(f_r), .g(f_g), .b(f_b)
  );

  // long-latency instance: PIX_LAT 7, default timing
  logic l_rst = 1'b1;
  logic [3:0] l_rin = 4'hA;
  logic [3:0] l_gin = 4'h5;
  logic [3:0] l_bin = 4'h3;
  logic l_ce, l_valid, l_ls, l_fs, l_hs, l_vs, l_de;
  logic [10:0] l_x, l_y;
  logic [3:0] l_r, l_g, l_b;

  vga_timing_gen #(.PIX_LAT(7)) u_lat7 (
    .clk(clk), .rst(l_rst), .rin(l_rin), .gin(l_gin), .bin(l_bin),
    .pix_ce(l_ce), .req_x(l_x), .req_y(l_y), .req_valid(l_valid),
    .line_start(l_ls), .frame_start(l_fs), .hsync(l_hs), .vsync(l_vs),
    .de(l_de), .r(l_r), .g(l_g), .b(l_b)
  );

  typedef struct {
    int n;
    int x;
    int y;
    bit valid;
    bit de;
    bit hs;
    bit vs;
    int r;
  } fvec_t;

  localparam int FN = 20;
  fvec_t ftab [FN];

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fi, ce_err, fol_err, prev_valid;
    int t, last_ce, per_err, hs_err, de_err, vs_err, first_low, last_low, low_cnt, de_cnt;
    int e, el, q, ql, exp_de, exp_hs_low;
    int fs_cnt, hs_fall, hs_low, vs_low, vs_first, prev_hs, found, first_de, de_r, de_g, de_b;

    // n: clk edges since release; x y valid de hs vs r observed at the following negedge
    ftab[0]  = '{0,  0,  0, 1, 0, 0, 0, 0};
    ftab[1]  = '{1,  1,  0, 1, 1, 0, 0, 0};
    ftab[2]  = '{5,  5,  0, 1, 1, 0, 0, 4};
    ftab[3]  = '{8,  8,  0, 0, 1, 0, 0, 7};
    ftab[4]  = '{9,  9,  0, 0, 0, 0, 0, 0};
    ftab[5]  = '{11, 11, 0, 0, 0, 1, 0, 0};
    ftab[6]  = '{12, 12, 0, 0, 0, 1, 0, 0};
    ftab[7]  = '{13, 13, 0, 0, 0, 0, 0, 0};
    ftab[8]  = '{14, 0,  1, 1, 0, 0, 0, 0};
    ftab[9]  = '{15, 1,  1, 1, 1, 0, 0, 0};
    ftab[10] = '{17, 3,  1, 1, 1, 0, 0, 2};
    ftab[11] = '{56, 0,  4, 0, 0, 0, 0, 0};
    ftab[12] = '{70, 0,  5, 0, 0, 0, 0, 0};
    ftab[13] = '{71, 1,  5, 0, 0, 0, 1, 0};
    ftab[14] = '{81, 11, 5, 0, 0, 1, 1, 0};
    ftab[15] = '{84, 0,  6, 0, 0, 0, 1, 0};
    ftab[16] = '{85, 1,  6, 0, 0, 0, 0, 0};
    ftab[17] = '{97, 13, 6, 0, 0, 0, 0, 0};
    ftab[18] = '{98, 0,  0, 1, 0, 0, 0, 0};
    ftab[19] = '{99, 1,  0, 1, 1, 0, 0, 0};

    repeat (3) @(negedge clk);

    // fast instance, table driven
    f_rst = 1'b0;
    fi = 0; ce_err = 0; fol_err = 0; prev_valid = 0;
    for (int n = 0; n < 100; n++) begin
      if (n > 0) @(negedge clk);
      if (f_ce !== 1'b1) ce_err++;
      if (n > 0 && int'(f_de) != prev_valid) fol_err++;
      prev_valid = int'(f_valid);
      if (fi < FN && ftab[fi].n == n) begin
        check($sformatf("fast_n%0d_req_x", n), int'(f_x), ftab[fi].x);
        check($sformatf("fast_n%0d_req_y", n), int'(f_y), ftab[fi].y);
        check($sformatf("fast_n%0d_req_valid", n), int'(f_valid), int'(ftab[fi].valid));
        check($sformatf("fast_n%0d_de", n), int'(f_de), int'(ftab[fi].de));
        check($sformatf("fast_n%0d_hsync", n), int'(f_hs), int'(ftab[fi].hs));
        check($sformatf("fast_n%0d_vsync", n), int'(f_vs), int'(ftab[fi].vs));
        check($sformatf("fast_n%0d_r", n), int'(f_r), ftab[fi].r);
        fi++;
      end
    end
    check("fast_rows_applied", fi, FN);
    check("fast_pix_ce_always_high_errors", ce_err, 0);
    check("fast_de_follows_req_valid_errors", fol_err, 0);

    // default instance: reset state, first clk, two lines
    check("def_reset_req_x", int'(d_x), 0);
    check("def_reset_req_y", int'(d_y), 0);
    check("def_reset_req_valid", int'(d_valid), 1);
    check("def_reset_de", int'(d_de), 0);
    check("def_reset_hsync", int'(d_hs), 1);
    check("def_reset_vsync", int'(d_vs), 1);
    check("def_reset_r", int'(d_r), 0);
    d_rst = 1'b0;
    check("def_first_pix_ce", int'(d_ce), 1);
    check("def_first_line_start", int'(d_ls), 1);
    check("def_first_frame_start", int'(d_fs), 1);

    t = -1; last_ce = -1; per_err = 0; hs_err = 0; de_err = 0; vs_err = 0;
    first_low = -1; last_low = -1; low_cnt = 0; de_cnt = 0;
    for (int c = 0; c < 7000 && t < 1700; c++) begin
      if (c > 0) @(negedge clk);
      if (d_ce) begin
        t++;
        if (last_ce >= 0 && c - last_ce != 4) per_err++;
        last_ce = c;
        if (t == 800) begin
          check("def_line1_line_start", int'(d_ls), 1);
          check("def_line1_req_x", int'(d_x), 0);
          check("def_line1_req_y", int'(d_y), 1);
          check("def_line1_frame_start", int'(d_fs), 0);
        end
        if (t >= 2) begin
          e = t - 1;
          el = e % 800;
          exp_hs_low = (el >= 657 && el <= 752) ? 1 : 0;
          if (int'(d_hs) != 1 - exp_hs_low) hs_err++;
          if (e < 800 && d_hs == 1'b0) begin
            if (first_low < 0) first_low = el;
            last_low = el;
            low_cnt++;
          end
          if (d_vs != 1'b1) vs_err++;
          q = e - 1;
          ql = q % 800;
          exp_de = (ql < 640) ? 1 : 0;
          if (int'(d_de) != exp_de) de_err++;
          if (int'(d_r) != (exp_de ? ql % 16 : 0)) de_err++;
          if (int'(d_g) != (exp_de ? 15 : 0)) de_err++;
          if (int'(d_b) != (exp_de ? 9 : 0)) de_err++;
          if (q < 800 && d_de) de_cnt++;
        end
      end
    end
    check("def_tick_budget", t, 1700);
    check("def_pix_ce_period_errors", per_err, 0);
    check("def_hsync_window_errors", hs_err, 0);
    check("def_hsync_first_low_tick", first_low, 657);
    check("def_hsync_last_low_tick", last_low, 752);
    check("def_hsync_low_ticks", low_cnt, 96);
    check("def_vsync_idle_errors", vs_err, 0);
    check("def_de_rgb_errors", de_err, 0);
    check("def_de_ticks_line0", de_cnt, 640);

    // small raster: wrap, frame_start, syncs, mid-frame reset
    @(negedge clk);
    m_rst = 1'b0;
    t = -1; fs_cnt = 0; hs_fall = 0; hs_low = 0; vs_low = 0; vs_first = -1; prev_hs = 1;
    for (int c = 0; c < 2000 && t < 779; c++) begin
      if (c > 0) @(negedge clk);
      if (m_ce) begin
        t++;
        if (m_fs) fs_cnt++;
        if (t == 389) begin
          check("mid_last_req_x", int'(m_x), 29);
          check("mid_last_req_y", int'(m_y), 12);
        end
        if (t == 390) begin
          check("mid_wrap_req_x", int'(m_x), 0);
          check("mid_wrap_req_y", int'(m_y), 0);
          check("mid_wrap_frame_start", int'(m_fs), 1);
        end
        if (t >= 1 && t <= 389) begin
          if (prev_hs == 1 && m_hs == 1'b0) hs_fall++;
          if (m_hs == 1'b0) hs_low++;
          if (m_vs == 1'b0) begin
            if (vs_first < 0) vs_first = t;
            vs_low++;
          end
        end
        prev_hs = int'(m_hs);
      end
    end
    check("mid_tick_budget", t, 779);
    check("mid_frame_start_count", fs_cnt, 2);
    check("mid_hsync_pulses", hs_fall, 13);
    check("mid_hsync_low_ticks", hs_low, 78);
    check("mid_vsync_low_ticks", vs_low, 60);
    check("mid_vsync_first_low_tick", vs_first, 242);

    found = 0;
    for (int c = 0; c < 2000 && found == 0; c++) begin
      @(negedge clk);
      if (m_x == 11'd10 && m_y == 11'd5) found = 1;
    end
    check("mid_reach_10_5", found, 1);
    check("mid_pre_reset_de", int'(m_de), 1);
    check("mid_pre_reset_r", int'(m_r), 8);
    m_rst = 1'b1;
    @(negedge clk);
    check("mid_rst_req_x", int'(m_x), 0);
    check("mid_rst_req_y", int'(m_y), 0);
    check("mid_rst_de", int'(m_de), 0);
    check("mid_rst_hsync", int'(m_hs), 1);
    check("mid_rst_vsync", int'(m_vs), 1);
    check("mid_rst_r", int'(m_r), 0);
    repeat (2) @(negedge clk);
    m_rst = 1'b0;
    check("mid_release_pix_ce", int'(m_ce), 1);
    check("mid_release_frame_start", int'(m_fs), 1);
    @(negedge clk);
    check("mid_after_release_pix_ce", int'(m_ce), 0);
    check("mid_after_release_req_x", int'(m_x), 1);

    // PIX_LAT 7: de rises 8 ticks after the first request
    @(negedge clk);
    l_rst = 1'b0;
    check("lat7_first_req_valid", int'(l_valid), 1);
    t = -1; first_de = -1; de_r = -1; de_g = -1; de_b = -1;
    for (int c = 0; c < 200 && t < 20; c++) begin
      if (c > 0) @(negedge clk);
      if (l_ce) begin
        t++;
        if (l_de && first_de < 0) begin
          first_de = t;
          de_r = int'(l_r);
          de_g = int'(l_g);
          de_b = int'(l_b);
        end
      end
    end
    check("lat7_de_rise_tick", first_de, 8);
    check("lat7_r", de_r, 10);
    check("lat7_g", de_g, 5);
    check("lat7_b", de_b, 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
